// File: rtl/arty_rst_pkg.sv
// Shared types and constants for the Arty SCR1 reset sequencer.
package arty_rst_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_SYS,
        ST_RUN,
        ST_SWRST
    } type_arty_rst_fsm_e;

    localparam logic [1:0] ARTY_RST_CAUSE_HARD = 2'b01;
    localparam logic [1:0] ARTY_RST_CAUSE_SW   = 2'b10;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/arty_rst_sync.sv
// Asynchronous-assert, synchronous-release reset synchronizer.
// Usable for any clock domain that needs a clean reset release.
module arty_rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_n_i,
    output logic rst_n_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/arty_rst_ctrl.sv
// Reset sequencer: synchronized hard-reset release, hold time, staged
// sys/core release, software warm reset and reset-cause recording.
//
// state    | meaning
// ST_RESET | hard reset asserted or release not yet synchronized
// ST_HOLD  | both resets held for the minimum assertion time
// ST_SYS   | system released, core still held
// ST_RUN   | both resets released, watching for warm-reset requests
// ST_SWRST | software reset asserted before the hold phase
module arty_rst_ctrl
    import arty_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned SYS_TO_CORE_DLY = 16,
    parameter int unsigned SW_RST_CYCLES   = 64
) (
    input  logic       clk_riscv,
    input  logic       hard_rst_in_n,
    input  logic       sw_rst_req,
    output logic       sys_rst_n,
    output logic       core_rst_n,
    output logic       rst_done,
    output logic [1:0] rst_cause,
    output logic       rst_led
);

    localparam int unsigned CNT_W =
        $clog2(max3(HOLD_CYCLES, SYS_TO_CORE_DLY, SW_RST_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LD  = CNT_W'(SYS_TO_CORE_DLY - 1);
    localparam logic [CNT_W-1:0] SW_LD   = CNT_W'(SW_RST_CYCLES - 1);

    type_arty_rst_fsm_e state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sw_req_q;
    logic               sys_rst_n_q;
    logic               core_rst_n_q;
    logic               rst_done_q;
    logic               rst_led_q;
    logic [1:0]         rst_cause_q;
    logic               rst_sync_n;

    arty_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_i    (clk_riscv),
        .arst_n_i (hard_rst_in_n),
        .rst_n_o  (rst_sync_n)
    );

    // sw_req_q resets high so a request held through hard reset never fires.
    always_ff @(posedge clk_riscv or negedge hard_rst_in_n) begin
        if (!hard_rst_in_n) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            sw_req_q     <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
            rst_done_q   <= 1'b0;
            rst_led_q    <= 1'b1;
            rst_cause_q  <= ARTY_RST_CAUSE_HARD;
        end else begin
            sw_req_q <= sw_rst_req;
            case (state_q)
                ST_RESET: begin
                    if (rst_sync_n) begin
                        cnt_q   <= HOLD_LD;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        sys_rst_n_q <= 1'b1;
                        cnt_q       <= SYS_LD;
                        state_q     <= ST_SYS;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SYS: begin
                    if (cnt_q == '0) begin
                        core_rst_n_q <= 1'b1;
                        rst_done_q   <= 1'b1;
                        rst_led_q    <= 1'b0;
                        state_q      <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req && !sw_req_q) begin
                        sys_rst_n_q  <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        rst_done_q   <= 1'b0;
                        rst_led_q    <= 1'b1;
                        rst_cause_q  <= ARTY_RST_CAUSE_SW;
                        cnt_q        <= SW_LD;
                        state_q      <= ST_SWRST;
                    end
                end
                ST_SWRST: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= HOLD_LD;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

    assign sys_rst_n  = sys_rst_n_q;
    assign core_rst_n = core_rst_n_q;
    assign rst_done   = rst_done_q;
    assign rst_led    = rst_led_q;
    assign rst_cause  = rst_cause_q;

endmodule

// File: doc/arty_rst_ctrl.md
# arty_rst_ctrl

Reset sequencer for the Arty SCR1 platform, between the raw reset sources (board RESETn, PLL lock, JTAG SRST, already ANDed into hard_rst_in_n) and the SoC. It synchronizes the combined reset and enforces a minimum assertion time. It then releases the system (AHB memories, UART, PIO) first and the SCR1 core a fixed delay later. It also performs software-requested warm resets and records the cause of the last reset.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for reset release; minimum 2.
- HOLD_CYCLES, 1024: cycles both resets stay asserted after the synchronized release; minimum 1.
- SYS_TO_CORE_DLY, 16: cycles between sys_rst_n release and core_rst_n release; minimum 1.
- SW_RST_CYCLES, 64: assertion length of a software reset before the HOLD phase; minimum 1.

Ports:
- clk_riscv, in, 1: core clock, 25 MHz.
- hard_rst_in_n, in, 1: reset, asynchronous, active-low. Clock clk_riscv.
- sw_rst_req, in, 1: warm-reset request from the system register, synchronous to clk_riscv; acted on at its rising edge.
- sys_rst_n, out, 1: system reset, active-low, registered.
- core_rst_n, out, 1: SCR1 core reset, active-low, registered.
- rst_done, out, 1: high while both resets are released.
- rst_cause, out, 2: cause of the last reset. 01 = hard, 10 = software. 00 and 11 are never driven.
- rst_led, out, 1: equals ~core_rst_n, for the board LED.

## Operation
- Assertion of hard_rst_in_n is asynchronous. It immediately clears the synchronizer, the FSM (to ST_RESET), the counter and all outputs.
- Release of hard_rst_in_n goes through a SYNC_STAGES flop chain clocked by clk_riscv, producing rst_sync_n.
- FSM states and transitions:
  - ST_RESET: on rst_sync_n=1, load counter with HOLD_CYCLES-1 and go to ST_HOLD.
  - ST_HOLD: decrement the counter. At 0, set sys_rst_n=1, load SYS_TO_CORE_DLY-1 and go to ST_SYS.
  - ST_SYS: decrement the counter. At 0, set core_rst_n=1 and rst_done=1, then go to ST_RUN.
  - ST_RUN: on a sw_rst_req rising edge, set sys_rst_n=0, core_rst_n=0 and rst_done=0. Also set rst_cause=10, load SW_RST_CYCLES-1 and go to ST_SWRST.
  - ST_SWRST: decrement the counter. At 0, load HOLD_CYCLES-1 and go to ST_HOLD.
- Edge detect uses a register sw_req_q with reset value 1. A request held high through hard reset does not trigger. A request held high across a warm reset does not retrigger; it must fall and rise again.
- A sw_rst_req edge outside ST_RUN is ignored and not queued.
- rst_cause is set to 01 only by hard_rst_in_n and to 10 only on entry to ST_SWRST. The warm reset does not clear it.
- The counter is a single down-counter shared by all phases. Its width is $clog2 of the largest of HOLD_CYCLES, SYS_TO_CORE_DLY and SW_RST_CYCLES, plus 1.
- The sw_rst_req input is only meaningful while sys_rst_n=1. Its source is in reset otherwise, and it must then be held low.

## Timing
- Reset values: sys_rst_n=0, core_rst_n=0, rst_done=0, rst_cause=01, rst_led=1, state ST_RESET, sw_req_q=1.
- Count edge 1 as the first clk_riscv rising edge sampling hard_rst_in_n=1.
- sys_rst_n goes high at edge SYNC_STAGES+HOLD_CYCLES+1.
- core_rst_n and rst_done go high exactly SYS_TO_CORE_DLY edges after sys_rst_n.
- Warm reset:
  - sw_rst_req is sampled high at edge N.
  - Both resets go low after edge N.
  - sys_rst_n goes high after edge N+SW_RST_CYCLES+HOLD_CYCLES.
  - core_rst_n follows SYS_TO_CORE_DLY edges later.
- Hard reset asserted in any state, including mid-countdown and ST_SWRST, drives all outputs to reset values with no clock required.
- All outputs are glitch-free flop outputs. No combinational path exists from any input to any output.

## Structure
- Package arty_rst_pkg holds:
  - the state typedef (type_arty_rst_fsm_e: ST_RESET, ST_HOLD, ST_SYS, ST_RUN, ST_SWRST);
  - the cause constants ARTY_RST_CAUSE_HARD=2'b01 and ARTY_RST_CAUSE_SW=2'b10.
- Sub-module arty_rst_sync is a parameterized asynchronous-assert, synchronous-release flop chain. It is reusable for the other clock domains.
- The top-level instantiates the block in place of the inline two-flop synchronizer. sys_rst_n feeds the system instance. core_rst_n feeds the SCR1 instance.

## Test plan
Benches use SYNC_STAGES=2, HOLD_CYCLES=8, SYS_TO_CORE_DLY=4, SW_RST_CYCLES=5.
- Power-on: release hard_rst_in_n. Required: sys_rst_n rises at edge 11, core_rst_n and rst_done at edge 15, rst_cause=01 throughout.
- Software reset: pulse sw_rst_req for 1 cycle, sampled at edge N in ST_RUN. Required: both resets low after N, sys_rst_n high after N+13, core_rst_n high after N+17, rst_cause=10.
- Held request: hold sw_rst_req high for 40 cycles. Required: exactly one warm reset. A second edge after return to ST_RUN produces a second warm reset.
- Mid-sequence hard reset: assert hard_rst_in_n at edge 6 of ST_HOLD and again during ST_SWRST. Required: immediate return to reset values, rst_cause=01, full power-on sequence timing on re-release.
- Ignored request and glitch: a sw_rst_req edge during ST_SYS causes no warm reset. A 1-cycle hard_rst_in_n low pulse in ST_RUN yields the full power-on timing.
